// File: rtl/text_overlay_pkg.sv
// Shared definitions for the WATERLOO ENG overlay text path.
// The text generator and its sequencer both import this package.
package text_overlay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TYPE,
        HOLD,
        BLINK,
        ERASE
    } seq_state_e;

    localparam logic [5:0] COLOR_GOLD = 6'b110110;
    localparam int TEXT_NUM_CHARS = 12;

endpackage

// File: rtl/frame_period_counter.sv
// Frame tick counter that flags the last tick of a programmable period
// and wraps, so consecutive periods run back to back.
module frame_period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] period,
    output logic             elapsed
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign elapsed = tick && (cnt_q == (period - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = elapsed ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/waterloo_text_sequencer.sv
// Typewriter reveal, hold, blink and erase sequencer for the overlay text.
// All visible changes land on frame_tick so the text never tears.
module waterloo_text_sequencer
    import text_overlay_pkg::*;
#(
    parameter int NUM_CHARS    = TEXT_NUM_CHARS,
    parameter int CHAR_FRAMES  = 6,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 15,
    parameter int BLINK_COUNT  = 3,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       start,
    input  logic       loop_en,
    input  logic       frame_tick,
    output logic [3:0] char_limit,
    output logic       text_on,
    output logic [5:0] text_rgb,
    output logic       busy,
    output logic       done
);

    localparam int BW = $clog2(2 * BLINK_COUNT + 1);
    localparam logic [3:0] NUM_L = 4'(NUM_CHARS);
    localparam logic [BW-1:0] BLINK_END = BW'(2 * BLINK_COUNT);

    seq_state_e state_q, state_d;
    logic [3:0] lim_q, lim_d;
    logic [BW-1:0] blink_q, blink_d;
    logic on_q, on_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic [CNT_W-1:0] period;
    logic elapsed;
    logic clr;

    always_comb begin
        unique case (state_q)
            HOLD:    period = CNT_W'(HOLD_FRAMES);
            BLINK:   period = CNT_W'(BLINK_FRAMES);
            default: period = CNT_W'(CHAR_FRAMES);
        endcase
    end

    // Idle keeps fc parked at zero, so a start+tick cycle is not counted.
    assign clr = (state_d != state_q) || (state_q == IDLE);

    frame_period_counter #(
        .CNT_W(CNT_W)
    ) u_fc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .tick   (frame_tick),
        .period (period),
        .elapsed(elapsed)
    );

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        blink_d = blink_q;
        on_d    = on_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            lim_d   = '0;
            blink_d = '0;
            on_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = TYPE;
                        lim_d   = '0;
                        on_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                TYPE: begin
                    if (elapsed && lim_q < NUM_L) begin
                        lim_d = lim_q + 4'd1;
                        if (lim_q + 4'd1 == NUM_L) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (elapsed) begin
                        state_d = BLINK;
                        on_d    = 1'b0;
                        blink_d = '0;
                    end
                end
                BLINK: begin
                    if (elapsed) begin
                        blink_d = blink_q + BW'(1);
                        // The final half-period ends "on", so erase starts visible.
                        if (blink_q + BW'(1) == BLINK_END) begin
                            state_d = ERASE;
                            on_d    = 1'b1;
                        end else begin
                            on_d = !on_q;
                        end
                    end
                end
                ERASE: begin
                    if (elapsed && lim_q != 4'd0) begin
                        lim_d = lim_q - 4'd1;
                        if (lim_q == 4'd1) begin
                            done_d  = 1'b1;
                            blink_d = '0;
                            if (loop_en) begin
                                state_d = TYPE;
                                on_d    = 1'b1;
                            end else begin
                                state_d = IDLE;
                                on_d    = 1'b0;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    lim_d   = '0;
                    blink_d = '0;
                    on_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lim_q   <= '0;
            blink_q <= '0;
            on_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            blink_q <= blink_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign char_limit = lim_q;
    assign text_on    = on_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign text_rgb   = COLOR_GOLD;

endmodule

// File: tb/tb_waterloo_text_sequencer.sv
// Directed bench for the overlay text sequencer: vector table plus
// hand-written async reset and done-pulse accounting.
module tb_waterloo_text_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       start;
    logic       loop_en;
    logic       frame_tick;
    logic [3:0] char_limit;
    logic       text_on;
    logic [5:0] text_rgb;
    logic       busy;
    logic       done;

    int n_pass;
    int n_total;
    int done_seen;

    typedef struct {
        int n;
        bit ft;
        bit st;
        bit en;
        bit lp;
        int lim;
        bit on;
        bit bsy;
        bit dn;
    } vec_t;

    vec_t vq[$];

    waterloo_text_sequencer #(
        .NUM_CHARS   (12),
        .CHAR_FRAMES (2),
        .HOLD_FRAMES (3),
        .BLINK_FRAMES(1),
        .BLINK_COUNT (2),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .start     (start),
        .loop_en   (loop_en),
        .frame_tick(frame_tick),
        .char_limit(char_limit),
        .text_on   (text_on),
        .text_rgb  (text_rgb),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit ft, input bit st, input bit en, input bit lp);
        frame_tick = ft;
        start      = st;
        enable     = en;
        loop_en    = lp;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        if (done) done_seen++;
    endtask

    task automatic add(input int n, input bit ft, input bit st, input bit en,
                       input bit lp, input int lim, input bit on,
                       input bit bsy, input bit dn);
        vec_t v;
        v.n = n; v.ft = ft; v.st = st; v.en = en; v.lp = lp;
        v.lim = lim; v.on = on; v.bsy = bsy; v.dn = dn;
        vq.push_back(v);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".lim"}, int'(char_limit), 0);
        chk({nm, ".on"}, int'(text_on), 0);
        chk({nm, ".busy"}, int'(busy), 0);
        chk({nm, ".done"}, int'(done), 0);
        chk({nm, ".rgb"}, int'(text_rgb), 54);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        done_seen  = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        start      = 1'b0;
        loop_en    = 1'b0;
        frame_tick = 1'b0;

        // n, ft, st, en, lp, lim, on, busy, done
        add(20, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1, 1, 0);
        add(8, 1, 0, 1, 0, 5, 1, 1, 0);
        add(1, 0, 1, 1, 0, 5, 1, 1, 0);
        add(14, 1, 0, 1, 0, 12, 1, 1, 0);
        add(2, 1, 0, 1, 0, 12, 1, 1, 0);
        add(1, 1, 0, 1, 0, 12, 0, 1, 0);
        add(1, 1, 0, 1, 0, 12, 1, 1, 0);
        add(1, 1, 0, 1, 0, 12, 0, 1, 0);
        add(1, 1, 0, 1, 0, 12, 1, 1, 0);
        add(1, 1, 0, 1, 0, 12, 1, 1, 0);
        add(1, 1, 0, 1, 0, 12, 1, 1, 0);
        add(1, 1, 0, 1, 0, 11, 1, 1, 0);
        add(21, 1, 0, 1, 0, 1, 1, 1, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(5, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 0, 1, 1, 0);
        add(24, 1, 0, 1, 1, 12, 1, 1, 0);
        add(3, 1, 0, 1, 1, 12, 0, 1, 0);
        add(4, 1, 0, 1, 1, 12, 1, 1, 0);
        add(23, 1, 0, 1, 1, 1, 1, 1, 0);
        add(1, 1, 0, 1, 1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 1, 0, 1, 1, 0);
        add(2, 1, 0, 1, 1, 1, 1, 1, 0);
        add(8, 1, 0, 1, 1, 5, 1, 1, 0);
        add(1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(3, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            for (int k = 0; k < vq[i].n; k++) begin
                cyc(vq[i].ft, vq[i].st && (k == 0), vq[i].en, vq[i].lp);
            end
            chk($sformatf("v%0d.lim", i), int'(char_limit), vq[i].lim);
            chk($sformatf("v%0d.on", i), int'(text_on), int'(vq[i].on));
            chk($sformatf("v%0d.busy", i), int'(busy), int'(vq[i].bsy));
            chk($sformatf("v%0d.done", i), int'(done), int'(vq[i].dn));
            chk($sformatf("v%0d.rgb", i), int'(text_rgb), 54);
        end

        // Walk on into the blink phase, then reset between clock edges.
        repeat (26) cyc(1, 0, 1, 0);
        chk("blink.on", int'(text_on), 1);
        chk("blink.lim", int'(char_limit), 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cyc(1, 0, 1, 1);
        chk_idle("post_rst");

        chk("done_pulses", done_seen, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
